fifo_write_control: RTL and testbench

FIFO_WRITE_CONTROL -- requirements
Module: fifo_write_control

---
 rtl/fifo_write_control.sv | 75 +++++++
 tb/tb_fifo_write_control.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_control.sv
// Write-side control for an asynchronous FIFO: binary/Gray write pointer,
// read-pointer synchronizer, registered full/almost-full/occupancy and sticky overflow.
module fifo_write_control #(
    parameter int addresssize = 4,
    parameter int afull_level = 28
) (
    input  logic                   wclk,
    input  logic                   wrst_n,
    input  logic                   winc,
    input  logic [addresssize+1:0] rptr,
    output logic                   wclken,
    output logic [addresssize:0]   waddr,
    output logic [addresssize+1:0] wptr,
    output logic                   wfull,
    output logic                   walmost_full,
    output logic [addresssize+1:0] wcount,
    output logic                   woverflow
);

    localparam int pw = addresssize + 2;
    localparam logic [pw-1:0] afull_thr = afull_level[pw-1:0];

    logic [pw-1:0] wbin;
    logic [pw-1:0] wbin_next;
    logic [pw-1:0] wgray_next;
    logic [pw-1:0] rq1;
    logic [pw-1:0] rq2;
    logic [pw-1:0] rbin_sync;
    logic [pw-1:0] occ_next;
    logic          full_next;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= rptr;
            rq2 <= rq1;
        end
    end

    always_comb begin
        rbin_sync = '0;
        for (int i = 0; i < pw; i++) begin
            rbin_sync[i] = ^(rq2 >> i);
        end
    end

    // Reset gates the enable so no memory write can slip through while wrst_n is low.
    assign wclken     = winc & ~wfull & wrst_n;
    assign waddr      = wbin[addresssize:0];
    assign wbin_next  = wbin + {{(pw-1){1'b0}}, wclken};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;
    assign occ_next   = wbin_next - rbin_sync;
    assign full_next  = (wgray_next == {~rq2[pw-1:pw-2], rq2[pw-3:0]});

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wcount       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= full_next;
            walmost_full <= (occ_next >= afull_thr);
            wcount       <= occ_next;
            woverflow    <= woverflow | (winc & wfull);
        end
    end

endmodule

// File: tb/tb_fifo_write_control.sv
// Directed bench for fifo_write_control: vector table plus multi-cycle corner sequences.
module tb_fifo_write_control;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       winc;
    logic [5:0] rptr;
    logic       wclken;
    logic [4:0] waddr;
    logic [5:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [5:0] wcount;
    logic       woverflow;

    int checks = 0;
    int errors = 0;

    fifo_write_control #(.addresssize(4), .afull_level(28)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .rptr(rptr),
        .wclken(wclken), .waddr(waddr), .wptr(wptr), .wfull(wfull),
        .walmost_full(walmost_full), .wcount(wcount), .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic       inc;
        logic [5:0] rp;
        logic       exp_en;
        logic [4:0] exp_addr;
        logic [5:0] exp_cnt;
        logic [5:0] exp_ptr;
        logic       exp_full;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic logic [5:0] gray(input logic [5:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        winc   = 1'b0;
        rptr   = 6'd0;
        wrst_n = 1'b0;
        #1;
        @(posedge wclk);
        #2;
        wrst_n = 1'b1;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wclken"}, wclken, 0);
        check({tag, "_waddr"}, waddr, 0);
        check({tag, "_wptr"}, wptr, 0);
        check({tag, "_wfull"}, wfull, 0);
        check({tag, "_walmost"}, walmost_full, 0);
        check({tag, "_wcount"}, wcount, 0);
        check({tag, "_wovf"}, woverflow, 0);
    endtask

    initial begin
        int         n;
        int         k;
        bit         blocked;
        bit         exp_en;
        logic [5:0] prev;
        logic [5:0] hist[$];

        // inc, rptr, wclken, waddr, wcount, wptr, wfull
        vecs[0] = '{1'b0, 6'd0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b0};
        vecs[1] = '{1'b1, 6'd0, 1'b1, 5'd0, 6'd1, 6'd1, 1'b0};
        vecs[2] = '{1'b1, 6'd0, 1'b1, 5'd1, 6'd2, 6'd3, 1'b0};
        vecs[3] = '{1'b0, 6'd0, 1'b0, 5'd2, 6'd2, 6'd3, 1'b0};
        vecs[4] = '{1'b1, 6'd0, 1'b1, 5'd2, 6'd3, 6'd2, 1'b0};
        vecs[5] = '{1'b0, 6'd1, 1'b0, 5'd3, 6'd3, 6'd2, 1'b0};
        vecs[6] = '{1'b0, 6'd1, 1'b0, 5'd3, 6'd3, 6'd2, 1'b0};
        vecs[7] = '{1'b0, 6'd1, 1'b0, 5'd3, 6'd2, 6'd2, 1'b0};
        vecs[8] = '{1'b1, 6'd1, 1'b1, 5'd3, 6'd3, 6'd6, 1'b0};

        // Reset state, with winc high to show the enable is gated.
        wrst_n = 1'b0;
        winc   = 1'b1;
        rptr   = 6'd0;
        #2;
        check_all_zero("rst");

        do_reset();
        for (int i = 0; i < 9; i++) begin
            winc = vecs[i].inc;
            rptr = vecs[i].rp;
            #1;
            check($sformatf("vec%0d_wclken", i), wclken, vecs[i].exp_en);
            check($sformatf("vec%0d_waddr", i), waddr, vecs[i].exp_addr);
            tick();
            check($sformatf("vec%0d_wcount", i), wcount, vecs[i].exp_cnt);
            check($sformatf("vec%0d_wptr", i), wptr, vecs[i].exp_ptr);
            check($sformatf("vec%0d_wfull", i), wfull, vecs[i].exp_full);
        end

        // Fill from empty with the read pointer parked at zero.
        do_reset();
        n       = 0;
        blocked = 1'b0;
        for (int i = 0; i < 40; i++) begin
            winc = 1'b1;
            #1;
            exp_en = (n < 32);
            check("fill_wclken", wclken, exp_en);
            if (exp_en) check("fill_waddr", waddr, n % 32);
            tick();
            if (exp_en) n++;
            else blocked = 1'b1;
            check("fill_wcount", wcount, n);
            check("fill_wfull", wfull, n == 32);
            check("fill_walmost", walmost_full, n >= 28);
            check("fill_wovf", woverflow, blocked);
        end

        // Drain one entry on the read side.
        winc = 1'b0;
        rptr = 6'b000001;
        k    = 0;
        while (wfull && k < 6) begin
            tick();
            k++;
        end
        check("drain_latency", (k >= 2) && (k <= 3), 1);
        check("drain_wfull", wfull, 0);
        check("drain_wcount", wcount, 31);
        check("drain_wovf_sticky", woverflow, 1);
        winc = 1'b1;
        #1;
        check("drain_wclken", wclken, 1);
        check("drain_waddr", waddr, 0);
        tick();
        winc = 1'b0;
        check("drain_refill_wcount", wcount, 32);
        check("drain_refill_wfull", wfull, 1);

        // Long stream with the read pointer trailing by four cycles.
        do_reset();
        n    = 0;
        prev = 6'd0;
        hist.delete();
        for (int i = 0; i < 100; i++) begin
            winc = 1'b1;
            #1;
            check("wrap_wclken", wclken, 1);
            check("wrap_waddr", waddr, n % 32);
            tick();
            n++;
            check("wrap_wptr", wptr, gray(n[5:0]));
            check("wrap_onebit", $countones(wptr ^ prev), 1);
            check("wrap_wfull", wfull, 0);
            check("wrap_wcount_le32", wcount <= 6'd32, 1);
            prev = wptr;
            hist.push_back(gray(n[5:0]));
            if (hist.size() > 4) rptr = hist.pop_front();
        end
        winc = 1'b0;

        // Reset pulled in the middle of a burst.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            winc = 1'b1;
            tick();
        end
        check("midrst_wcount17", wcount, 17);
        #2;
        wrst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) begin
            @(negedge wclk);
            check("midrst_hold_wclken", wclken, 0);
            check("midrst_hold_wcount", wcount, 0);
        end
        @(posedge wclk);
        #2;
        wrst_n = 1'b1;
        #1;
        check("midrst_rel_wclken", wclken, 1);
        check("midrst_rel_waddr", waddr, 0);
        tick();
        check("midrst_rel_wcount", wcount, 1);
        check("midrst_rel_wptr", wptr, 1);
        winc = 1'b0;

        // Write and read-pointer advance land on the same edge.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            winc = 1'b1;
            tick();
        end
        winc = 1'b0;
        check("simul_wcount10", wcount, 10);
        rptr = 6'b000001;
        tick();
        tick();
        check("simul_pre_wcount", wcount, 10);
        winc = 1'b1;
        #1;
        check("simul_wclken", wclken, 1);
        tick();
        winc = 1'b0;
        check("simul_wcount", wcount, 10);
        check("simul_wfull", wfull, 0);
        tick();
        check("simul_after_wcount", wcount, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
